aes_wb_ctrl: RTL and testbench
==============================

Name: aes_wb_ctrl

Overview:
- Wishbone-slave register bank and sequencer that owns the 128-bit AES engine inside the user project area.
- Firmware writes key, block and command words over Wishbone; the block runs key expansion, then block processing, and captures the result.
- Raises user_irq[0] on completion.
- Sits between the wrapper's wbs_* bus and the AES datapath core.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode is wbs_adr_i[31:8] == BASE_ADDR[31:8].
- TIMEOUT_CYC, 1024, watchdog limit in clocks (used only with the optional feature).
- CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data.
- core_key  out  128  key to engine.
- core_block  out  128  block to engine.
- core_encdec  out  1  1 = encrypt.
- core_init  out  1  one-cycle key-expansion start pulse.
- core_next  out  1  one-cycle block start pulse.
- core_ready  in  1  engine idle/ready.
- core_result  in  128  engine output.
- core_result_valid  in  1  result valid level.
- irq_o  out  1  completion interrupt, drives user_irq[0].

Behaviour:
- Reset (async assert, sync release): all outputs 0; all registers 0; FSM in IDLE.
- Register map (adr[7:2]):
  - 0x00 CTRL: bit0 START (self-clearing), bit1 ENCDEC, bit2 IRQ_EN, bit3 KEEP_KEY (skip key expansion).
  - 0x04 STATUS: RO bit0 busy, bit1 done, bit2 timeout; write-1-to-clear for bits 1 and 2.
  - 0x10–0x1C KEY0..3 (KEY0 = key[127:96]).
  - 0x20–0x2C BLK0..3.
  - 0x30–0x3C RES0..3, read-only.
  - Unmapped offsets: read 0, writes ignored.
- Wishbone: ack asserts one cycle after cyc&stb&decode and is held for exactly one cycle. Writes honour wbs_sel_i per byte. No back-to-back ack: ack is deasserted for at least one cycle between transfers.
- Writes to KEY, BLK or CTRL.ENCDEC while busy=1 are acked but ignored.
- FSM states and transitions:
  - IDLE: on START write, go to KINIT if KEEP_KEY=0 or no key has yet been expanded since reset; otherwise go to BSTART. busy=1 from the cycle after the START ack.
  - KINIT: core_init=1 for one cycle → KWAIT.
  - KWAIT: when core_ready=1 → BSTART. The core_ready sample is ignored on the first cycle after the pulse.
  - BSTART: core_next=1 for one cycle → BWAIT.
  - BWAIT: when core_ready=1 and core_result_valid=1 → DONE. This check is also masked for one cycle after the pulse.
  - DONE: RES0..3 ← core_result; done=1; busy=0; → IDLE.
- Simultaneous START and done clear in one write: clear applies first, then the new operation starts.
- START while busy: ignored; no error flag.
- irq_o = done & IRQ_EN, registered. It clears the cycle after the done bit is W1C-cleared or IRQ_EN is written 0.
- Reset mid-operation: FSM returns to IDLE and all registers return to 0. No core pulses are issued afterwards until a new START.

Optional Feature:
- Macro AES_WB_CTRL_TIMEOUT_EN.
- Defined: a CNT_W-bit counter clears on entry to KWAIT and to BWAIT and increments each cycle in those states. When it reaches TIMEOUT_CYC, the FSM goes to IDLE, timeout=1, done=0, busy=0, RES is unchanged, and irq_o asserts if IRQ_EN=1.
- Undefined: no counter; KWAIT and BWAIT wait indefinitely; STATUS bit2 reads 0.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - the FSM state enum;
  - register offset constants (OFF_CTRL, OFF_STATUS, OFF_KEY0, OFF_BLK0, OFF_RES0);
  - CTRL and STATUS bit-index constants.
- One sub-module, aes_wb_regs: Wishbone decode, ack generation and the register bank.
- The FSM and watchdog stay in aes_wb_ctrl.

Test Plan:
- Reset register check: assert wb_rst_n_i=0 mid-BWAIT → all outputs 0 immediately; after release, STATUS reads 0x0 and no core_init/core_next pulse appears.
- FIPS-197 run: key 000102…0f, block 00112233…ff, ENCDEC=1, IRQ_EN=1, START. Model core ready after 10 clocks → exactly one core_init and one core_next pulse; RES0..3 = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a; irq_o=1; W1C 0x2 to STATUS → irq_o=0 the next cycle.
- KEEP_KEY=1 second run with a new block → no core_init pulse; one core_next pulse; result captured.
- Writes while busy: write KEY0=0xdeadbeef during KWAIT → acked, KEY0 unchanged. Second START during BWAIT is ignored.
- Byte-enable write: BLK0 with wbs_sel_i=4'b0010 and data 0x0000AB00 → only bits [15:8]=0xAB change. Read of offset 0x40 → 0, single-cycle ack.
- With AES_WB_CTRL_TIMEOUT_EN defined and TIMEOUT_CYC=16: hold core_ready=0 → after 16 cycles in KWAIT, timeout=1, busy=0, irq_o=1. Without the macro: still busy after 100 cycles.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES Wishbone controller: FSM states,
// register offsets, CTRL/STATUS bit positions and a byte-lane merge helper.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KINIT,
    ST_KWAIT,
    ST_BSTART,
    ST_BWAIT,
    ST_DONE
  } state_e;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_KEY0   = 8'h10;
  localparam logic [7:0] OFF_BLK0   = 8'h20;
  localparam logic [7:0] OFF_RES0   = 8'h30;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ENCDEC   = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_KEEP_KEY = 3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_TIMEOUT = 2;

  // Replace only the byte lanes selected by sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_wb_regs.sv
// Wishbone slave decode, single-cycle registered ack and the AES register bank
// (CTRL, STATUS, KEY0..3, BLK0..3, RES0..3).
module aes_wb_regs
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cyc,
  input  logic         stb,
  input  logic         we,
  input  logic [3:0]   sel,
  input  logic [31:0]  adr,
  input  logic [31:0]  wdata,
  output logic         ack,
  output logic [31:0]  rdata,
  input  logic         busy,
  input  logic         capture,
  input  logic         timeout_evt,
  input  logic [127:0] result,
  output logic [127:0] key,
  output logic [127:0] block,
  output logic         encdec,
  output logic         keep_key,
  output logic         start,
  output logic         irq
);

  logic         req, wr, wr_ctrl, wr_stat, wr_key, wr_blk;
  logic [7:0]   off;
  logic [6:0]   lsb;
  logic [1:0]   unused_adr;
  logic         irq_en, done, timeout;
  logic         irq_en_d, done_d, timeout_d, encdec_d, keep_key_d, start_d;
  logic [127:0] res;
  logic [31:0]  rd_word;

  assign off        = {adr[7:2], 2'b00};
  assign unused_adr = adr[1:0];
  // Word 0 of each 128-bit register is its most significant 32 bits.
  assign lsb        = {~adr[3:2], 5'b00000};

  // ~ack guarantees an idle cycle between consecutive acks.
  assign req     = cyc & stb & ~ack & (adr[31:8] == BASE_ADDR[31:8]);
  assign wr      = req & we;
  assign wr_ctrl = wr & (off == OFF_CTRL);
  assign wr_stat = wr & (off == OFF_STATUS);
  assign wr_key  = wr & ~busy & (off[7:4] == OFF_KEY0[7:4]);
  assign wr_blk  = wr & ~busy & (off[7:4] == OFF_BLK0[7:4]);

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rd_word = '0;
    if (off == OFF_CTRL) begin
      rd_word[CTRL_ENCDEC]   = encdec;
      rd_word[CTRL_IRQ_EN]   = irq_en;
      rd_word[CTRL_KEEP_KEY] = keep_key;
    end else if (off == OFF_STATUS) begin
      rd_word[STAT_BUSY]    = busy;
      rd_word[STAT_DONE]    = done;
      rd_word[STAT_TIMEOUT] = timeout;
    end else if (off[7:4] == OFF_KEY0[7:4]) begin
      rd_word = key[lsb +: 32];
    end else if (off[7:4] == OFF_BLK0[7:4]) begin
      rd_word = block[lsb +: 32];
    end else if (off[7:4] == OFF_RES0[7:4]) begin
      rd_word = res[lsb +: 32];
    end
  end

  // Control/status next values: W1C first, then START, then FSM events.
  always_comb begin
    irq_en_d   = irq_en;
    done_d     = done;
    timeout_d  = timeout;
    encdec_d   = encdec;
    keep_key_d = keep_key;
    start_d    = 1'b0;
    if (wr_stat && sel[0]) begin
      if (wdata[STAT_DONE])    done_d    = 1'b0;
      if (wdata[STAT_TIMEOUT]) timeout_d = 1'b0;
    end
    if (wr_ctrl && sel[0]) begin
      irq_en_d   = wdata[CTRL_IRQ_EN];
      keep_key_d = wdata[CTRL_KEEP_KEY];
      if (!busy) begin
        encdec_d = wdata[CTRL_ENCDEC];
        if (wdata[CTRL_START]) begin
          start_d   = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
    end
    if (capture) begin
      done_d    = 1'b1;
      timeout_d = 1'b0;
    end
    if (timeout_evt) begin
      timeout_d = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      rdata    <= '0;
      key      <= '0;
      block    <= '0;
      res      <= '0;
      encdec   <= 1'b0;
      keep_key <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      start    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ack      <= req;
      rdata    <= (req && !we) ? rd_word : '0;
      encdec   <= encdec_d;
      keep_key <= keep_key_d;
      irq_en   <= irq_en_d;
      done     <= done_d;
      timeout  <= timeout_d;
      start    <= start_d;
      irq      <= (done_d | timeout_d) & irq_en_d;
      if (wr_key) key[lsb +: 32]   <= merge_bytes(key[lsb +: 32], wdata, sel);
      if (wr_blk) block[lsb +: 32] <= merge_bytes(block[lsb +: 32], wdata, sel);
      if (capture) res <= result;
    end
  end

endmodule

// File: rtl/aes_wb_ctrl.sv
// AES engine sequencer behind a Wishbone register bank: key expansion, block
// processing, result capture and completion IRQ. Optional watchdog on the
// engine wait states is enabled by defining AES_WB_CTRL_TIMEOUT_EN.
module aes_wb_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid,
  output logic         irq_o
);

  state_e state_q, state_d;
  logic   busy, start, keep_key, capture_c, timeout_c, tmo_hit;
  logic   mask_q, key_valid_q;

  assign busy = (state_q != ST_IDLE);

  aes_wb_regs #(
    .BASE_ADDR(BASE_ADDR)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .cyc        (wbs_cyc_i),
    .stb        (wbs_stb_i),
    .we         (wbs_we_i),
    .sel        (wbs_sel_i),
    .adr        (wbs_adr_i),
    .wdata      (wbs_dat_i),
    .ack        (wbs_ack_o),
    .rdata      (wbs_dat_o),
    .busy       (busy),
    .capture    (capture_c),
    .timeout_evt(timeout_c),
    .result     (core_result),
    .key        (core_key),
    .block      (core_block),
    .encdec     (core_encdec),
    .keep_key   (keep_key),
    .start      (start),
    .irq        (irq_o)
  );

`ifdef AES_WB_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             in_wait;

  assign in_wait = (state_q == ST_KWAIT) || (state_q == ST_BWAIT);
  assign tmo_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Cleared on every state change so each wait state starts from zero.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)             cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (in_wait)            cnt_q <= cnt_q + CNT_W'(1);
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = CNT_W'(TIMEOUT_CYC);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = (!keep_key || !key_valid_q) ? ST_KINIT : ST_BSTART;
      ST_KINIT:  state_d = ST_KWAIT;
      ST_KWAIT: begin
        if (!mask_q && core_ready) begin
          state_d = ST_BSTART;
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timeout_c = 1'b1;
        end
      end
      ST_BSTART: state_d = ST_BWAIT;
      ST_BWAIT: begin
        if (!mask_q && core_ready && core_result_valid) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timeout_c = 1'b1;
        end
      end
      ST_DONE: begin
        capture_c = 1'b1;
        state_d   = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pulses are registered; mask_q blinds the ready check for the cycle after a pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      mask_q      <= 1'b0;
      key_valid_q <= 1'b0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= core_init | core_next;
      core_init <= (state_d == ST_KINIT);
      core_next <= (state_d == ST_BSTART);
      if (state_q == ST_KINIT) key_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_wb_ctrl.sv
// Directed/randomised bench for aes_wb_ctrl with a behavioural AES engine stand-in
// and a register-level reference model of the firmware-visible state.
module tb_aes_wb_ctrl;

  localparam logic [31:0]  BASE    = 32'h3000_0000;
  localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]   sel = '0;
  logic [31:0]  adr = '0, dat_w = '0;
  logic         ack, encdec, c_init, c_next, irq;
  logic [31:0]  dat_r;
  logic [127:0] core_key, core_block;

  logic         core_ready = 1'b1;
  logic         core_valid = 1'b0;
  logic [127:0] core_result = '0;
  logic [127:0] pending = '0;
  logic         core_op = 1'b0;
  logic         stall = 1'b0;
  int           core_cnt = 0;
  int           n_init = 0, n_next = 0;
  int           total = 0, bad = 0;

  logic [31:0]  m_key[4];
  logic [31:0]  m_blk[4];

  always #5 clk = ~clk;

  aes_wb_ctrl #(
    .BASE_ADDR  (BASE),
    .TIMEOUT_CYC(16),
    .CNT_W      (11)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_n_i       (rst_n),
    .wbs_cyc_i        (cyc),
    .wbs_stb_i        (stb),
    .wbs_we_i         (we),
    .wbs_sel_i        (sel),
    .wbs_adr_i        (adr),
    .wbs_dat_i        (dat_w),
    .wbs_ack_o        (ack),
    .wbs_dat_o        (dat_r),
    .core_key         (core_key),
    .core_block       (core_block),
    .core_encdec      (encdec),
    .core_init        (c_init),
    .core_next        (c_next),
    .core_ready       (core_ready),
    .core_result      (core_result),
    .core_result_valid(core_valid),
    .irq_o            (irq)
  );

  // Engine stand-in: real FIPS-197 answer for the FIPS vector, a keyed mix otherwise.
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] b,
                                            input logic e);
    if (k == FIPS_K && b == FIPS_PT && e) return FIPS_CT;
    return b ^ {k[63:0], k[127:64]} ^ {128{e}};
  endfunction

  // Engine timing: goes busy on a pulse and is ready again 10 clocks later.
  always @(posedge clk) begin
    if (c_init) n_init <= n_init + 1;
    if (c_next) n_next <= n_next + 1;
    if (c_init || c_next) begin
      core_ready <= 1'b0;
      core_valid <= 1'b0;
      core_cnt   <= 10;
      core_op    <= c_next;
      if (c_next) pending <= fake_aes(core_key, core_block, encdec);
    end else if (core_cnt > 0 && !stall) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_ready <= 1'b1;
        if (core_op) begin
          core_valid  <= 1'b1;
          core_result <= pending;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        rd  = dat_r;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", got, 1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb(1'b1, BASE | 32'(off), d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    wb(1'b0, BASE | 32'(off), 32'h0, 4'hF, r);
  endtask

  function automatic logic [127:0] cat4(input logic [31:0] w[4]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic load_regs();
    for (int i = 0; i < 4; i++) begin
      wr(8'(8'h10 + 4 * i), m_key[i]);
      wr(8'(8'h20 + 4 * i), m_blk[i]);
    end
  endtask

  task automatic wait_next(input int base);
    for (int c = 0; c < 100 && n_next <= base; c++) begin
      @(posedge clk); #1;
    end
    chk("next_pulse_seen", n_next > base, 1);
  endtask

  task automatic wait_done();
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < 40; c++) begin
      rd(8'h04, r);
      if (r[1]) break;
    end
    chk("status_done", r, 32'h2);
  endtask

  task automatic check_res(input logic [127:0] exp);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      rd(8'(8'h30 + 4 * i), r);
      chk($sformatf("res%0d", i), r, exp[127 - 32 * i -: 32]);
    end
  endtask

  initial begin
    logic [31:0]  r, d;
    logic [127:0] fk, exp_res;
    logic [3:0]   s;
    logic         enc;
    int           i0, n0, acks;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key", core_key, 0);
    chk("rst_block", core_block, 0);
    chk("rst_ctl_outs", {ack, encdec, c_init, c_next, irq}, 0);
    chk("rst_dat", dat_r, 0);
    rst_n = 1'b1;
    rd(8'h04, r);
    chk("status_after_reset", r, 0);

    // FIPS-197 run with a locked-key write and an ignored START while busy
    fk = FIPS_K;
    for (int i = 0; i < 4; i++) m_key[i] = fk[127 - 32 * i -: 32];
    fk = FIPS_PT;
    for (int i = 0; i < 4; i++) m_blk[i] = fk[127 - 32 * i -: 32];
    load_regs();
    chk("core_key", core_key, cat4(m_key));
    chk("core_block", core_block, cat4(m_blk));
    wr(8'h00, 32'h6);
    i0 = n_init;
    n0 = n_next;
    wr(8'h00, 32'h7);
    wr(8'h10, 32'hdeadbeef);
    rd(8'h10, r);
    chk("key0_locked", r, m_key[0]);
    rd(8'h04, r);
    chk("busy_bit", r[0], 1);
    wait_next(n0);
    wr(8'h00, 32'h7);
    wait_done();
    chk("fips_init_pulses", n_init - i0, 1);
    chk("fips_next_pulses", n_next - n0, 1);
    chk("fips_encdec", encdec, 1);
    check_res(FIPS_CT);
    chk("irq_set", irq, 1);
    wr(8'h04, 32'h2);
    chk("irq_clear", irq, 0);
    rd(8'h04, r);
    chk("status_cleared", r, 0);

    // KEEP_KEY: reuse expanded key with a new block
    for (int i = 0; i < 4; i++) m_blk[i] = $urandom;
    for (int i = 0; i < 4; i++) wr(8'(8'h20 + 4 * i), m_blk[i]);
    i0 = n_init;
    n0 = n_next;
    wr(8'h00, 32'hF);
    wait_done();
    chk("keep_init_pulses", n_init - i0, 0);
    chk("keep_next_pulses", n_next - n0, 1);
    check_res(fake_aes(cat4(m_key), cat4(m_blk), 1'b1));

    // Random key/block/direction runs with key expansion
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < 4; i++) begin
        m_key[i] = $urandom;
        m_blk[i] = $urandom;
      end
      enc = 1'($urandom_range(0, 1));
      load_regs();
      i0 = n_init;
      n0 = n_next;
      wr(8'h00, {28'h0, 1'b0, 1'b1, enc, 1'b1});
      chk("rand_encdec", encdec, enc);
      wait_done();
      chk("rand_init_pulses", n_init - i0, 1);
      chk("rand_next_pulses", n_next - n0, 1);
      chk("rand_irq", irq, 1);
      exp_res = fake_aes(cat4(m_key), cat4(m_blk), enc);
      check_res(exp_res);
    end

    // Byte enables
    wb(1'b1, BASE | 32'h20, 32'h0000AB00, 4'b0010, r);
    m_blk[0] = {m_blk[0][31:16], 8'hAB, m_blk[0][7:0]};
    rd(8'h20, r);
    chk("blk0_sel", r, m_blk[0]);
    chk("blk0_core", core_block[127:96], m_blk[0]);
    s = 4'($urandom_range(0, 15));
    d = $urandom;
    wb(1'b1, BASE | 32'h18, d, s, r);
    for (int b = 0; b < 4; b++) if (s[b]) m_key[2][8 * b +: 8] = d[8 * b +: 8];
    rd(8'h18, r);
    chk("key2_sel", r, m_key[2]);
    chk("key2_core", core_key[63:32], m_key[2]);

    // Unmapped offset: zero data, ack for exactly one cycle even with stb held
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h40;
    @(posedge clk); #1;
    chk("unmapped_ack", ack, 1);
    chk("unmapped_data", dat_r, 0);
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 0);
    cyc = 1'b0; stb = 1'b0;

    // Outside the decode window: never acked
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h100;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("no_ack_outside", acks, 0);

    // Reset in the middle of BWAIT
    n0 = n_next;
    wr(8'h00, 32'h7);
    wait_next(n0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_key_blk", {core_key, core_block} == '0, 1);
    chk("midrst_ctl_outs", {ack, encdec, c_init, c_next, irq}, 0);
    chk("midrst_dat", dat_r, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i0 = n_init;
    n0 = n_next;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_pulses", (n_init - i0) + (n_next - n0), 0);
    rd(8'h04, r);
    chk("midrst_status", r, 0);
    rd(8'h10, r);
    chk("midrst_key0", r, 0);

    // Engine never ready: watchdog or indefinite wait
    stall = 1'b1;
    n0 = n_next;
    wr(8'h00, 32'h7);
    repeat (100) @(posedge clk);
    rd(8'h04, r);
`ifdef AES_WB_CTRL_TIMEOUT_EN
    chk("stall_status", r, 32'h4);
    chk("stall_irq", irq, 1);
`else
    chk("stall_status", r, 32'h1);
    chk("stall_irq", irq, 0);
`endif
    chk("stall_no_next", n_next - n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
